// File: rtl/adder_accum_ctrl.sv
// rtl/adder_accum_ctrl.sv - batch accumulator controller around an external 6-bit adder
//
// Purpose:
//   Drives an external combinational adder with X = incoming operand and
//   Y = running sum. Captures the adder's S output back into the accumulator
//   and counts its carry-outs. After N_OPS operands, it presents the batch
//   sum and the carry count on a valid/ready output.
//
// Optional feature (macro ADDER_ACC_SAT_EN):
//   When this macro is defined, any accepted add with a carry-out loads
//   all-ones into the accumulator, so the sum saturates. When it is not
//   defined, the accumulator wraps modulo 2^W.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data  operand stream
//   add_x, add_y               to the adder (operand, accumulator)
//   add_s, add_cout            from the adder
//   out_valid/out_ready        batch result handshake
//   out_sum, out_carries       registered batch sum and saturating carry count
//   busy                       batch partially accumulated or result held
module adder_accum_ctrl #(
  parameter int W     = 6,
  parameter int N_OPS = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [W-1:0]     add_x,
  output logic [W-1:0]     add_y,
  input  logic [W-1:0]     add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       LAST_IDX = 4'(N_OPS - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [3:0]       op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_carries_q, out_carries_d;
  logic             busy_q, busy_d;

  logic [W-1:0]     acc_next;
  logic [CNT_W-1:0] car_inc;

  // The operand goes straight to the adder so that S and cout are valid in the
  // same cycle as the handshake that consumes them.
  assign add_x       = in_data;
  assign add_y       = acc_q;
  // in_ready is held low during reset and rises as soon as reset is released,
  // without waiting for a clock edge.
  assign in_ready    = ~rst & (state_q != DONE);
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_carries = out_carries_q;
  assign busy        = busy_q;

`ifdef ADDER_ACC_SAT_EN
  assign acc_next = add_cout ? {W{1'b1}} : add_s;
`else
  assign acc_next = add_s;
`endif

  // The carry counter stops at its maximum value instead of wrapping.
  assign car_inc = (car_cnt_q == CNT_MAX) ? car_cnt_q : car_cnt_q + CNT_W'(add_cout);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    op_cnt_d      = op_cnt_q;
    car_cnt_d     = car_cnt_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_carries_d = out_carries_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d     = acc_next;
          car_cnt_d = CNT_W'(add_cout);
          op_cnt_d  = 4'd1;
          busy_d    = 1'b1;
          state_d   = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d     = acc_next;
          car_cnt_d = car_inc;
          op_cnt_d  = op_cnt_q + 4'd1;
          if (op_cnt_q == LAST_IDX) begin
            out_sum_d     = acc_next;
            out_carries_d = car_inc;
            out_valid_d   = 1'b1;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        // The result registers keep their values after the output handshake.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          op_cnt_d    = '0;
          car_cnt_d   = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      op_cnt_q      <= '0;
      car_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_carries_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      op_cnt_q      <= op_cnt_d;
      car_cnt_q     <= car_cnt_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_carries_q <= out_carries_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// tb/tb_adder_accum_ctrl.sv - directed bench for adder_accum_ctrl
module tb_adder_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [5:0] add_x;
  logic [5:0] add_y;
  logic [5:0] add_s;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic [2:0] out_carries;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Model of the external 6-bit combinational adder.
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y};

  adder_accum_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .add_x       (add_x),
    .add_y       (add_y),
    .add_s       (add_s),
    .add_cout    (add_cout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .busy        (busy)
  );

  task automatic send_op(input logic [5:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0d exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0d exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    total++; if (out_sum !== 6'd0) begin bad++; $display("FAIL rst_out_sum got=%0d exp=0", out_sum); end
    total++; if (out_carries !== 3'd0) begin bad++; $display("FAIL rst_out_carries got=%0d exp=0", out_carries); end
    total++; if (add_y !== 6'd0) begin bad++; $display("FAIL rst_add_y got=%0d exp=0", add_y); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0d exp=1", in_ready); end
  endtask

  task automatic test_basic();
    send_op(6'd1);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0d exp=1", busy); end
    total++; if (add_y !== 6'd1) begin bad++; $display("FAIL basic_acc1 got=%0d exp=1", add_y); end
    send_op(6'd2);
    send_op(6'd3);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0d exp=0", out_valid); end
    send_op(6'd4);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0d exp=1", out_valid); end
    total++; if (out_sum !== 6'd10) begin bad++; $display("FAIL basic_out_sum got=%0d exp=10", out_sum); end
    total++; if (out_carries !== 3'd0) begin bad++; $display("FAIL basic_out_carries got=%0d exp=0", out_carries); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready got=%0d exp=0", in_ready); end
    drain();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain_valid got=%0d exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_drain_busy got=%0d exp=0", busy); end
    total++; if (out_sum !== 6'd10) begin bad++; $display("FAIL basic_sum_held got=%0d exp=10", out_sum); end
    total++; if (add_y !== 6'd0) begin bad++; $display("FAIL basic_acc_cleared got=%0d exp=0", add_y); end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_sum;
    logic [2:0] exp_car;
`ifdef ADDER_ACC_SAT_EN
    exp_sum = 6'd63;
    exp_car = 3'd3;
`else
    exp_sum = 6'd32;
    exp_car = 3'd2;
`endif
    for (int i = 0; i < 4; i++) send_op(6'd40);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_out_valid got=%0d exp=1", out_valid); end
    total++; if (out_sum !== exp_sum) begin bad++; $display("FAIL wrap_out_sum got=%0d exp=%0d", out_sum, exp_sum); end
    total++; if (out_carries !== exp_car) begin bad++; $display("FAIL wrap_out_carries got=%0d exp=%0d", out_carries, exp_car); end
    drain();
  endtask

  task automatic test_backpressure();
    send_op(6'd10);
    send_op(6'd11);
    send_op(6'd12);
    send_op(6'd13);
    // Offer an operand throughout DONE; it must not be taken.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 6'd7;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0d exp=1", i, out_valid); end
      total++; if (out_sum !== 6'd46) begin bad++; $display("FAIL bp_sum cyc=%0d got=%0d exp=46", i, out_sum); end
      total++; if (out_carries !== 3'd0) begin bad++; $display("FAIL bp_carries cyc=%0d got=%0d exp=0", i, out_carries); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0d exp=0", i, in_ready); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy cyc=%0d got=%0d exp=1", i, busy); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%0d exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%0d exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%0d exp=0", busy); end
    total++; if (add_y !== 6'd0) begin bad++; $display("FAIL bp_operand_not_taken got=%0d exp=0", add_y); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (add_y !== 6'd7) begin bad++; $display("FAIL bp_operand_taken_idle got=%0d exp=7", add_y); end
    send_op(6'd1);
    send_op(6'd1);
    send_op(6'd1);
    @(negedge clk);
    total++; if (out_sum !== 6'd10) begin bad++; $display("FAIL bp_next_batch_sum got=%0d exp=10", out_sum); end
    drain();
  endtask

  task automatic test_reset_mid();
    send_op(6'd9);
    send_op(6'd9);
    #2;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0d exp=0", busy); end
    total++; if (add_y !== 6'd0) begin bad++; $display("FAIL mid_rst_acc got=%0d exp=0", add_y); end
    total++; if (out_sum !== 6'd0) begin bad++; $display("FAIL mid_rst_out_sum got=%0d exp=0", out_sum); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%0d exp=0", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_release_ready got=%0d exp=1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_output got=%0d exp=0", out_valid); end
    end
    for (int i = 0; i < 4; i++) send_op(6'd5);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_rst_batch_valid got=%0d exp=1", out_valid); end
    total++; if (out_sum !== 6'd20) begin bad++; $display("FAIL mid_rst_batch_sum got=%0d exp=20", out_sum); end
    total++; if (out_carries !== 3'd0) begin bad++; $display("FAIL mid_rst_batch_carries got=%0d exp=0", out_carries); end
    drain();
  endtask

  task automatic test_gaps();
    send_op(6'd7);
    repeat (3) begin
      @(negedge clk);
      total++; if (add_y !== 6'd7) begin bad++; $display("FAIL gap_acc got=%0d exp=7", add_y); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%0d exp=1", busy); end
    end
    send_op(6'd7);
    send_op(6'd7);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_early_valid got=%0d exp=0", out_valid); end
    send_op(6'd7);
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gap_out_valid got=%0d exp=1", out_valid); end
    total++; if (out_sum !== 6'd28) begin bad++; $display("FAIL gap_out_sum got=%0d exp=28", out_sum); end
    drain();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
